// File: rtl/fetch_top.sv
// Instruction fetch front end: one outstanding memory request, a single-entry
// output register toward decode, a one-entry hold buffer and redirect squashing.
module fetch_top #(
    parameter int                PC_WIDTH    = 32,
    parameter int                INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] BOOT_PC   = PC_WIDTH'(32'h0000_1000)
) (
    input  logic                   clock,
    input  logic                   reset_c,
    output logic                   imem_req_valid,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   stall_decode,
    output logic                   fetch_instr_valid,
    output logic [INSTR_WIDTH-1:0] fetch_instr_data,
    output logic [PC_WIDTH-1:0]    fetch_instr_pc,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   excV,
    input  logic [PC_WIDTH-1:0]    rmPC
);

    // state  | meaning
    // S_REQ  | presenting imem request for pc
    // S_WAIT | request accepted, waiting for its response
    // S_HOLD | response parked in hold buffer until decode frees output
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t                 state, state_nxt;
    logic [PC_WIDTH-1:0]    pc, pc_nxt;
    logic                   squash, squash_nxt;
    logic [INSTR_WIDTH-1:0] hold_data;
    logic [PC_WIDTH-1:0]    hold_pc;
    logic                   take_rsp, park_rsp, unpark;

    logic                   redirect;
    logic [PC_WIDTH-1:0]    target;
    logic                   free;

    assign redirect = excV | branch_taken;
    assign target   = excV ? rmPC : branch_target;
    assign free     = ~fetch_instr_valid | ~stall_decode;

    always_ff @(posedge clock) begin
        if (reset_c) begin
            state  <= S_REQ;
            pc     <= BOOT_PC;
            squash <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            squash <= squash_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        squash_nxt = squash;
        take_rsp   = 1'b0;
        park_rsp   = 1'b0;
        unpark     = 1'b0;
        case (state)
            S_REQ: begin
                if (redirect) pc_nxt = target;
                // an accepted request races a redirect: let it complete, then drop its data
                if (imem_req_ready) begin
                    state_nxt  = S_WAIT;
                    squash_nxt = redirect;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt  = S_REQ;
                    squash_nxt = 1'b0;
                    if (redirect) begin
                        pc_nxt = target;
                    end else if (!squash) begin
                        pc_nxt = pc + PC_WIDTH'(4);
                        if (free) begin
                            take_rsp = 1'b1;
                        end else begin
                            park_rsp  = 1'b1;
                            state_nxt = S_HOLD;
                        end
                    end
                end else if (redirect) begin
                    pc_nxt     = target;
                    squash_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = S_REQ;
                end else if (free) begin
                    unpark    = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = (state == S_REQ);
        imem_req_addr  = pc;
    end

    always_ff @(posedge clock) begin
        if (reset_c) begin
            fetch_instr_valid <= 1'b0;
            fetch_instr_data  <= '0;
            fetch_instr_pc    <= '0;
            hold_data         <= '0;
            hold_pc           <= '0;
        end else begin
            if (redirect) begin
                fetch_instr_valid <= 1'b0;
            end else if (take_rsp) begin
                fetch_instr_valid <= 1'b1;
                fetch_instr_data  <= imem_rsp_data;
                fetch_instr_pc    <= pc;
            end else if (unpark) begin
                fetch_instr_valid <= 1'b1;
                fetch_instr_data  <= hold_data;
                fetch_instr_pc    <= hold_pc;
            end else if (free) begin
                fetch_instr_valid <= 1'b0;
            end
            if (park_rsp) begin
                hold_data <= imem_rsp_data;
                hold_pc   <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_top.sv
// Bench for fetch_top: directed boot/stall/squash/priority/wrap/backpressure/reset
// scenarios, then random traffic against an in-order program-stream model.
module tb_fetch_top;

    logic        clock = 1'b0;
    logic        reset_c;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_decode;
    logic        fetch_instr_valid;
    logic [31:0] fetch_instr_data;
    logic [31:0] fetch_instr_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        excV;
    logic [31:0] rmPC;

    int total = 0;
    int bad   = 0;

    fetch_top dut (
        .clock(clock), .reset_c(reset_c),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .stall_decode(stall_decode),
        .fetch_instr_valid(fetch_instr_valid), .fetch_instr_data(fetch_instr_data),
        .fetch_instr_pc(fetch_instr_pc), .branch_taken(branch_taken),
        .branch_target(branch_target), .excV(excV), .rmPC(rmPC)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        stall_decode = 1'b0; branch_taken = 1'b0; branch_target = '0;
        excV = 1'b0; rmPC = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_c = 1'b1;
        tick(); tick();
        reset_c = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_c = 1'b1;
        tick(); tick();
        total++; if (fetch_instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", fetch_instr_valid); end
        total++; if (fetch_instr_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", fetch_instr_data); end
        total++; if (fetch_instr_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", fetch_instr_pc); end
        reset_c = 1'b0;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1000) begin
            bad++; $display("FAIL reset_req got=%0b/%h exp=1/00001000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_boot();
        do_reset();
        imem_req_ready = 1'b1;
        total++; if (imem_req_addr !== 32'h1000) begin bad++; $display("FAIL boot_addr got=%h exp=00001000", imem_req_addr); end
        tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL boot_wait_req got=%0b exp=0", imem_req_valid); end
        tick();
        imem_rsp_valid = 1'b0;
        total++; if (fetch_instr_valid !== 1'b1 || fetch_instr_data !== 32'h1234_5678 || fetch_instr_pc !== 32'h1000) begin
            bad++; $display("FAIL boot_out got=%0b/%h/%h exp=1/12345678/00001000", fetch_instr_valid, fetch_instr_data, fetch_instr_pc); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1004) begin
            bad++; $display("FAIL boot_next got=%0b/%h exp=1/00001004", imem_req_valid, imem_req_addr); end
    endtask

    // continues from test_boot: output valid at 0x1000, requesting 0x1004
    task automatic test_stall();
        stall_decode = 1'b1; imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAAAA_0001;
        tick();
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        for (int i = 0; i < 3; i++) begin
            total++; if (fetch_instr_valid !== 1'b1 || fetch_instr_data !== 32'h1234_5678 || fetch_instr_pc !== 32'h1000) begin
                bad++; $display("FAIL stall_hold_out got=%0b/%h/%h exp=1/12345678/00001000", fetch_instr_valid, fetch_instr_data, fetch_instr_pc); end
            total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_no_req got=%0b exp=0", imem_req_valid); end
            tick();
        end
        stall_decode = 1'b0;
        tick();
        total++; if (fetch_instr_valid !== 1'b1 || fetch_instr_data !== 32'hAAAA_0001 || fetch_instr_pc !== 32'h1004) begin
            bad++; $display("FAIL stall_release got=%0b/%h/%h exp=1/aaaa0001/00001004", fetch_instr_valid, fetch_instr_data, fetch_instr_pc); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1008) begin
            bad++; $display("FAIL stall_next_req got=%0b/%h exp=1/00001008", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_squash();
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h2000;
        tick();
        branch_taken = 1'b0;
        tick();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL squash_wait got=%0b exp=0", imem_req_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_DEAD;
        tick();
        imem_rsp_valid = 1'b0;
        total++; if (fetch_instr_valid !== 1'b0) begin bad++; $display("FAIL squash_drop got=%0b/%h exp=0", fetch_instr_valid, fetch_instr_data); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000) begin
            bad++; $display("FAIL squash_next got=%0b/%h exp=1/00002000", imem_req_valid, imem_req_addr); end
        tick();
        total++; if (fetch_instr_valid !== 1'b0) begin bad++; $display("FAIL squash_late got=%0b exp=0", fetch_instr_valid); end
    endtask

    task automatic test_priority();
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0BAD_F00D;
        tick();
        imem_rsp_valid = 1'b0; stall_decode = 1'b1;
        excV = 1'b1; rmPC = 32'h0100; branch_taken = 1'b1; branch_target = 32'h2000;
        tick();
        excV = 1'b0; branch_taken = 1'b0;
        total++; if (imem_req_addr !== 32'h0100) begin bad++; $display("FAIL prio_addr got=%h exp=00000100", imem_req_addr); end
        total++; if (fetch_instr_valid !== 1'b0) begin bad++; $display("FAIL prio_valid got=%0b exp=0", fetch_instr_valid); end
        stall_decode = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        total++; if (imem_req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got=%h exp=fffffffc", imem_req_addr); end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0055;
        tick();
        imem_rsp_valid = 1'b0;
        total++; if (fetch_instr_pc !== 32'hFFFF_FFFC || fetch_instr_data !== 32'h55) begin
            bad++; $display("FAIL wrap_out got=%h/%h exp=fffffffc/00000055", fetch_instr_pc, fetch_instr_data); end
        total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h exp=00000000", imem_req_addr); end
    endtask

    // continues from test_wrap: output valid, requesting 0x0
    task automatic test_backpressure();
        stall_decode = 1'b1; imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
                bad++; $display("FAIL bp_req cyc=%0d got=%0b/%h exp=1/00000000", i, imem_req_valid, imem_req_addr); end
            total++; if (fetch_instr_valid !== 1'b1 || fetch_instr_data !== 32'h55 || fetch_instr_pc !== 32'hFFFF_FFFC) begin
                bad++; $display("FAIL bp_out cyc=%0d got=%0b/%h/%h exp=1/00000055/fffffffc", i, fetch_instr_valid, fetch_instr_data, fetch_instr_pc); end
        end
        stall_decode = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; reset_c = 1'b1;
        tick();
        reset_c = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0BAD;
        tick();
        imem_rsp_valid = 1'b0;
        total++; if (fetch_instr_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b exp=0", fetch_instr_valid); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1000) begin
            bad++; $display("FAIL rstmid_req got=%0b/%h exp=1/00001000", imem_req_valid, imem_req_addr); end
    endtask

    // Model: decode must see the program stream in order starting at BOOT_PC,
    // each instruction equal to memory contents, restarting at every redirect target.
    task automatic test_random();
        logic [31:0] exp_pc, snap_data, snap_pc, out_addr, t;
        logic        outstanding, hold_chk, br, ex;
        int          lat, consumed;
        do_reset();
        exp_pc = 32'h1000; outstanding = 1'b0; hold_chk = 1'b0; lat = 0; consumed = 0;
        out_addr = '0; snap_data = '0; snap_pc = '0;
        for (int c = 0; c < 4000; c++) begin
            if (hold_chk) begin
                total++; if (fetch_instr_valid !== 1'b1 || fetch_instr_data !== snap_data || fetch_instr_pc !== snap_pc) begin
                    bad++; $display("FAIL rnd_stall_hold cyc=%0d got=%0b/%h/%h exp=1/%h/%h", c, fetch_instr_valid, fetch_instr_data, fetch_instr_pc, snap_data, snap_pc); end
            end
            if (outstanding) begin
                total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rnd_one_outstanding cyc=%0d got=%0b exp=0", c, imem_req_valid); end
            end
            stall_decode   = ($urandom_range(0, 9) < 3);
            imem_req_ready = ($urandom_range(0, 9) < 6);
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
            if (outstanding) begin
                if (lat == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(out_addr);
                    outstanding    = 1'b0;
                end else begin
                    lat--;
                end
            end
            br = ($urandom_range(0, 24) == 0);
            ex = ($urandom_range(0, 39) == 0);
            t = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF8;
            branch_taken = br; branch_target = t;
            excV = ex; rmPC = $urandom() & 32'hFFFF_FFFC;
            if (fetch_instr_valid && !stall_decode) begin
                total++; if (fetch_instr_pc !== exp_pc || fetch_instr_data !== mem_word(exp_pc)) begin
                    bad++; $display("FAIL rnd_stream cyc=%0d got=%h/%h exp=%h/%h", c, fetch_instr_pc, fetch_instr_data, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (ex) exp_pc = rmPC;
            else if (br) exp_pc = branch_target;
            hold_chk  = fetch_instr_valid && stall_decode && !ex && !br;
            snap_data = fetch_instr_data;
            snap_pc   = fetch_instr_pc;
            if (imem_req_valid && imem_req_ready) begin
                outstanding = 1'b1;
                out_addr    = imem_req_addr;
                lat         = $urandom_range(0, 3);
            end
            tick();
        end
        idle_inputs();
        total++; if (consumed < 100) begin bad++; $display("FAIL rnd_progress got=%0d exp>=100", consumed); end
    endtask

    initial begin
        idle_inputs();
        reset_c = 1'b1;
        test_reset();
        test_boot();
        test_stall();
        test_squash();
        test_priority();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_top.md
FETCH_TOP -- requirements
Module: fetch_top

Parameters
REQ-001 SHALL have parameter PC_WIDTH, default 32, width of program counter and memory address.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, width of one instruction word.
REQ-003 SHALL have parameter BOOT_PC, default 32'h0000_1000, PC loaded at reset.

Interface
REQ-004 SHALL provide port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL provide port reset_c  in  1  synchronous, active-high reset.
REQ-006 SHALL provide port imem_req_valid  out  1  instruction fetch request.
REQ-007 SHALL provide port imem_req_addr  out  PC_WIDTH  fetch address.
REQ-008 SHALL provide port imem_req_ready  in  1  memory accepts request this cycle.
REQ-009 SHALL provide port imem_rsp_valid  in  1  instruction data returned this cycle.
REQ-010 SHALL provide port imem_rsp_data  in  INSTR_WIDTH  returned instruction.
REQ-011 SHALL provide port stall_decode  in  1  decode cannot accept; hold output.
REQ-012 SHALL provide port fetch_instr_valid  out  1  instruction presented to decode.
REQ-013 SHALL provide port fetch_instr_data  out  INSTR_WIDTH  instruction to decode.
REQ-014 SHALL provide port fetch_instr_pc  out  PC_WIDTH  PC of presented instruction.
REQ-015 SHALL provide port branch_taken  in  1  branch redirect request.
REQ-016 SHALL provide port branch_target  in  PC_WIDTH  branch redirect PC.
REQ-017 SHALL provide port excV  in  1  exception redirect request.
REQ-018 SHALL provide port rmPC  in  PC_WIDTH  exception handler PC.

Function
REQ-019 SHALL implement FSM states REQ, WAIT, HOLD, with at most one outstanding memory request.
REQ-020 In REQ SHALL drive imem_req_valid=1, imem_req_addr=pc; on imem_req_ready go to WAIT; otherwise stay REQ with address stable.
REQ-021 imem_req_valid SHALL be 0 in WAIT and HOLD.
REQ-022 Output register is "free" when fetch_instr_valid=0 or stall_decode=0.
REQ-023 In WAIT on imem_rsp_valid (not squashed): if free, load output {1, rsp_data, pc}, pc<=pc+4, go REQ; else capture into hold buffer, pc<=pc+4, go HOLD.
REQ-024 In HOLD SHALL move hold buffer to output and go REQ in the first cycle the output is free.
REQ-025 When free and no new load occurs, fetch_instr_valid SHALL go to 0 next cycle (instruction consumed).
REQ-026 While stall_decode=1 and fetch_instr_valid=1, output data, pc and valid SHALL hold unchanged.
REQ-027 pc+4 SHALL wrap modulo 2^PC_WIDTH (0xFFFF_FFFC -> 0x0000_0000).
REQ-028 Redirect = excV or branch_taken; excV SHALL take priority; target = rmPC if excV else branch_target.
REQ-029 On redirect SHALL: pc<=target, fetch_instr_valid<=0, discard hold buffer, next state REQ unless an accepted request remains outstanding.
REQ-030 Redirect in REQ with imem_req_ready=1 same cycle: request is accepted for the old pc, squash flag set, go WAIT.
REQ-031 Redirect in WAIT without imem_rsp_valid: set squash flag, stay WAIT.
REQ-032 Redirect in WAIT with imem_rsp_valid same cycle: response dropped, squash stays 0, go REQ.
REQ-033 Response in WAIT with squash=1: dropped, squash cleared, go REQ; pc not incremented.
REQ-034 A new redirect while squash=1 SHALL update pc only; squash remains 1.
REQ-035 Latency: request accept to fetch_instr_valid = response cycle + 1 when output free.

Reset
REQ-036 On reset_c=1 at a clock edge SHALL set state=REQ, pc=BOOT_PC, squash=0, hold buffer empty, fetch_instr_valid=0, fetch_instr_data=0, fetch_instr_pc=0; imem_req_valid=1 from the first cycle after reset.
REQ-037 Reset mid-transaction SHALL abandon any outstanding request; a response arriving after reset without a prior accepted request SHALL be ignored.

Verification
REQ-038 Boot: release reset, ready=1, response 1 cycle later with 0x12345678 -> first addr 0x1000, fetch_instr_valid=1, data 0x12345678, pc 0x1000; next request addr 0x1004.
REQ-039 Stall: stall_decode=1 with output valid, response 0xAAAA0001 arrives -> state HOLD, output unchanged; stall released -> output 0xAAAA0001, pc 0x1004, no request issued in HOLD.
REQ-040 Squash: branch_taken target 0x2000 while WAIT, response 0xDEAD arrives later -> 0xDEAD never presented; next request addr 0x2000.
REQ-041 Priority: excV rmPC 0x0100 and branch_taken target 0x2000 same cycle -> next request addr 0x0100, fetch_instr_valid=0.
REQ-042 Wrap: branch to 0xFFFFFFFC, response returned -> next request addr 0x00000000.
REQ-043 Backpressure: imem_req_ready=0 for 5 cycles -> imem_req_valid=1 and addr stable all 5 cycles, no output change.
